// File: rtl/warning_annunciator.sv
// warning_annunciator: turns vehicle_safety priority flags and per-fault bits
// into chime bursts, blinking/solid lamps, driver ack/mute and a fault code.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   warn_pri2     critical warning flag (preempts everything)
//   warn_pri1     non-critical warning flag
//   warn_vec[6:0] SEAT DOOR HOOD TRUNK BAT AIRBAG TEMP
//   ack           driver acknowledge
//   chime_out     buzzer drive
//   lamp[6:0]     per-fault lamps (blink while unacknowledged)
//   master_lamp   OR of warn_vec
//   active_code   0 = none, else 1 + index of lowest set warn_vec bit
//   silenced      high while muted
module warning_annunciator #(
    parameter int unsigned TICK_DIV        = 100000,
    parameter int unsigned PRI2_ON         = 100,
    parameter int unsigned PRI2_OFF        = 100,
    parameter int unsigned PRI1_ON         = 200,
    parameter int unsigned PRI1_OFF        = 800,
    parameter int unsigned BLINK_HALF      = 500,
    parameter int unsigned MAX_PRI1_CHIMES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       warn_pri2,
    input  logic       warn_pri1,
    input  logic [6:0] warn_vec,
    input  logic       ack,
    output logic       chime_out,
    output logic [6:0] lamp,
    output logic       master_lamp,
    output logic [2:0] active_code,
    output logic       silenced
);

    localparam int unsigned M2   = (PRI2_ON > PRI2_OFF) ? PRI2_ON : PRI2_OFF;
    localparam int unsigned M1   = (PRI1_ON > PRI1_OFF) ? PRI1_ON : PRI1_OFF;
    localparam int unsigned PMAX = (M2 > M1) ? M2 : M1;
    localparam int unsigned CW   = $clog2(PMAX * TICK_DIV + 1);
    localparam int unsigned BW   = $clog2(BLINK_HALF * TICK_DIV + 1);
    localparam int unsigned NW   = $clog2(MAX_PRI1_CHIMES + 1);

    typedef enum logic [2:0] {
        IDLE,
        P2_ON,
        P2_OFF,
        P1_ON,
        P1_OFF,
        MUTED
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] pre;
    logic [CW-1:0] ph;
    logic [CW-1:0] ph_last;
    logic          tick_end;
    logic          ph_done;
    logic          trans;
    logic [NW-1:0] cnt;
    logic [NW-1:0] cnt_nxt;
    logic [NW-1:0] cnt_inc;
    logic [6:0]    prev;
    logic [6:0]    rise;
    logic [6:0]    fall;
    logic [6:0]    unacked;
    logic [6:0]    unacked_nxt;
    logic [BW-1:0] bcnt;
    logic          bwrap;
    logic          blink;
    logic          blink_nxt;
    logic [2:0]    code_nxt;

    assign rise     = warn_vec & ~prev;
    assign fall     = prev & ~warn_vec;
    assign tick_end = (pre == CW'(TICK_DIV - 1));
    assign ph_done  = tick_end && (ph == ph_last);
    assign trans    = (state_nxt != state);
    assign cnt_inc  = cnt + NW'(1);

    assign bwrap     = (bcnt == BW'(BLINK_HALF * TICK_DIV - 1));
    assign blink_nxt = blink ^ bwrap;

    // A rising bit survives a simultaneous ack; everything else is cleared.
    assign unacked_nxt = rise | (ack ? 7'b0 : (unacked & ~fall));

    always_comb begin
        ph_last = '0;
        unique case (state)
            P2_ON:   ph_last = CW'(PRI2_ON - 1);
            P2_OFF:  ph_last = CW'(PRI2_OFF - 1);
            P1_ON:   ph_last = CW'(PRI1_ON - 1);
            P1_OFF:  ph_last = CW'(PRI1_OFF - 1);
            default: ph_last = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (warn_pri2) begin
            unique case (state)
                P2_ON:   state_nxt = ph_done ? P2_OFF : P2_ON;
                P2_OFF:  state_nxt = ph_done ? P2_ON : P2_OFF;
                default: state_nxt = P2_ON;
            endcase
        end else if (warn_pri1) begin
            unique case (state)
                P1_ON: begin
                    if (ack) begin
                        state_nxt = MUTED;
                    end else if (ph_done) begin
                        state_nxt = P1_OFF;
                    end
                end
                P1_OFF: begin
                    if (ack) begin
                        state_nxt = MUTED;
                    end else if (ph_done) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= NW'(MAX_PRI1_CHIMES)) begin
                            state_nxt = MUTED;
                        end else begin
                            state_nxt = P1_ON;
                        end
                    end
                end
                MUTED: begin
                    if (|rise) begin
                        state_nxt = P1_ON;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = P1_ON;
                    cnt_nxt   = '0;
                end
            endcase
        end else begin
            state_nxt = IDLE;
        end
    end

    // Lowest-index active fault wins the code.
    always_comb begin
        code_nxt = '0;
        for (int i = 6; i >= 0; i--) begin
            if (warn_vec[i]) begin
                code_nxt = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pre         <= '0;
            ph          <= '0;
            prev        <= '0;
            unacked     <= '0;
            bcnt        <= '0;
            blink       <= 1'b1;
            chime_out   <= 1'b0;
            lamp        <= '0;
            master_lamp <= 1'b0;
            active_code <= '0;
            silenced    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            prev    <= warn_vec;
            unacked <= unacked_nxt;
            blink   <= blink_nxt;
            bcnt    <= bwrap ? '0 : bcnt + BW'(1);
            if (trans) begin
                pre <= '0;
                ph  <= '0;
            end else if (tick_end) begin
                pre <= '0;
                ph  <= ph + CW'(1);
            end else begin
                pre <= pre + CW'(1);
            end
            chime_out   <= (state_nxt == P2_ON) || (state_nxt == P1_ON);
            silenced    <= (state_nxt == MUTED);
            lamp        <= warn_vec & (~unacked_nxt | {7{blink_nxt}});
            master_lamp <= |warn_vec;
            active_code <= code_nxt;
        end
    end

endmodule
